demux_1_4_buf: RTL and testbench
================================

Name: demux_1_4_buf

Overview:
- Registered 1-to-4 demultiplexer. It steers one valid/ready input word stream to one of four output lanes, chosen by a 2-bit select sent with each word.
- Each lane has its own 2-entry FIFO, so a stalled destination only blocks words addressed to it.
- Used in the core to distribute results and requests from one producer to four consumers, for example write-back fan-out and peripheral request routing.

Parameters:
- XLEN, 32, data width of the input word and of each lane output.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- f  input  XLEN  input data word.
- s  input  2  lane select for f: 00 to a, 01 to b, 10 to c, 11 to d.
- in_valid  input  1  f/s are valid this cycle.
- in_ready  output  1  block can accept f into lane s this cycle.
- a  output  XLEN  lane 0 head data.
- b  output  XLEN  lane 1 head data.
- c  output  XLEN  lane 2 head data.
- d  output  XLEN  lane 3 head data.
- out_valid  output  4  bit i set means lane i head data is valid.
- out_ready  input  4  bit i set means the lane i consumer takes the head this cycle.
- lane_cnt  output  8  2 bits per lane, lane i in [2i+1:2i], occupancy 0..2.

Behaviour:
- Reset: rst_n low asynchronously empties all lanes.
  - out_valid=4'b0000, lane_cnt=0, a/b/c/d=0.
  - in_ready is forced 0 while rst_n is low; it follows its normal rule from the first clock after release.
- Push: when in_valid && in_ready at a clock edge, f is written to the tail of lane s.
- in_ready = (lane_cnt[s] != 2).
  - It depends only on the selected lane's occupancy, never on out_ready, so there is no combinational ready-to-ready path.
  - When lane s is full, a same-cycle pop on s does not make room for a push that cycle.
- Pop: for each lane i independently, when out_valid[i] && out_ready[i] at a clock edge, the head entry is removed.
- Latency:
  - A word accepted at edge N appears on its lane output, with out_valid set, after edge N (one cycle).
  - There is no combinational bypass from f to a/b/c/d.
- Output data: a/b/c/d show the lane head while the lane is non-empty and drive 0 when it is empty. out_valid[i] = (cnt_i != 0).
- Ordering: strict FIFO order within each lane. There is no ordering guarantee between lanes.
- Lane FIFO: 2 entries with 1-bit read and write pointers, wrapping 1 to 0.
  - Count update per lane: push only +1, pop only -1, push and pop together leaves the count unchanged.
  - Simultaneous push and pop is legal at cnt=1 and cnt=2? No: at cnt=2 the push is refused (see in_ready). At cnt=1, head and tail advance together.
- Unselected lanes are unaffected by the input side and keep draining independently in the same cycle.
- in_valid low: no push regardless of s. s and f are ignored.
- Stall semantics: the producer must hold f/s stable while in_valid && !in_ready. The block does not check this.
- Reset mid-operation: all queued data is discarded and no lane asserts out_valid until a new push.
- out_ready asserted on an empty lane has no effect. The count never underflows below 0 or exceeds 2.

Test Plan:
- Reset, then push f=32'h1111_0000 with s=01 and in_valid=1 for one cycle.
  - Required: the next cycle shows out_valid=4'b0010, b=32'h1111_0000, lane_cnt=8'b00_00_01_00, and a/c/d=0.
- Lane full, out_ready=0: push 32'hA, 32'hB, 32'hC to s=10 on consecutive cycles.
  - Required: in_ready=0 on the third cycle, so C is not accepted, and lane_cnt[5:4]=2.
  - Then raise out_ready[2]: c shows A then B on successive cycles, and in_ready rises one cycle after the first pop.
- Head-of-line isolation: lane 0 full with out_ready[0]=0, then push 32'h55 with s=11.
  - Required: accepted immediately, d=32'h55 on the next cycle, lane 0 untouched.
- Simultaneous push and pop on lane 3 at cnt=1, head 32'h1: push 32'h2 while out_ready[3]=1.
  - Required: d=32'h2 on the next cycle, lane_cnt[7:6] stays 1.
- Async reset mid-traffic: with lanes 0 and 2 holding 2 entries, pulse rst_n low between clock edges.
  - Required: out_valid=0, lane_cnt=0, a..d=0 immediately, with no stale data after rst_n returns high.
- Random stress: 10k cycles of random in_valid/s/f/out_ready.
  - Required: the scoreboard shows per-lane FIFO order and no loss or duplication, lane_cnt matches the model, and in_ready never rises while lane s is full.

Source files
------------

// File: rtl/demux_1_4_buf.sv
// Two-entry lane FIFO: push to tail, pop from head, head reads 0 when empty.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: pushes are ignored at cnt=2 and pops are ignored at cnt=0.
module demux_lane_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  // Guards keep the count in 0..2 even if a caller misbehaves.
  assign do_push = push && (cnt_q != 2'd2);
  assign do_pop  = pop  && (cnt_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdat;
        wptr      <= ~wptr;
      end
      if (do_pop) begin
        rptr <= ~rptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head = (cnt_q != 2'd0) ? mem[rptr] : '0;
  assign cnt  = cnt_q;

endmodule

// Registered 1-to-4 demux: word f goes to lane s, each lane a private 2-entry FIFO.
// Latency: one cycle from accept edge to lane output; no f-to-output bypass.
// Backpressure: in_ready drops only when lane s is full; other lanes keep draining.
module demux_1_4_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f,
  input  logic [1:0]      s,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [XLEN-1:0] c,
  output logic [XLEN-1:0] d,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [7:0]      lane_cnt
);

  logic [XLEN-1:0] head [4];
  logic [1:0]      cnt  [4];
  logic [3:0]      push;
  logic [3:0]      pop;
  logic            rdy_en;

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Ready looks only at the selected lane's occupancy, never at out_ready.
  assign in_ready = rdy_en && (cnt[s] != 2'd2);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign push[i]      = in_valid && in_ready && (s == 2'(i));
    assign pop[i]       = out_valid[i] && out_ready[i];
    assign out_valid[i] = (cnt[i] != 2'd0);
    assign lane_cnt[2*i +: 2] = cnt[i];

    demux_lane_fifo #(
      .W (XLEN)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .wdat  (f),
      .pop   (pop[i]),
      .head  (head[i]),
      .cnt   (cnt[i])
    );
  end

  assign a = head[0];
  assign b = head[1];
  assign c = head[2];
  assign d = head[3];

endmodule

// File: tb/tb_demux_1_4_buf.sv
// Directed and random bench for demux_1_4_buf with a per-lane queue scoreboard.
module tb_demux_1_4_buf;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] f;
  logic [1:0]      s;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a, b, c, d;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [7:0]      lane_cnt;

  demux_1_4_buf #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f         (f),
    .s         (s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_cnt  (lane_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned     ntests = 0;
  int unsigned     nfail  = 0;
  logic [XLEN-1:0] sb [4][$];
  logic            rdy_en;
  logic            exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the scoreboard state before the next edge.
  task automatic check_model();
    logic [XLEN-1:0] got [4];
    logic [XLEN-1:0] exp_head;
    logic [7:0]      exp_cnt;
    #1;
    got[0] = a; got[1] = b; got[2] = c; got[3] = d;
    exp_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      exp_head = (sb[i].size() != 0) ? sb[i][0] : '0;
      exp_cnt[2*i +: 2] = 2'(sb[i].size());
      chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(sb[i].size() != 0));
      chk($sformatf("head[%0d]", i), got[i], exp_head);
    end
    chk("lane_cnt", 32'(lane_cnt), 32'(exp_cnt));
    exp_rdy = rdy_en && (sb[s].size() != 2);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  // One clock: check, then apply the handshakes seen at the edge to the model.
  task automatic step();
    check_model();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (out_ready[i] && sb[i].size() != 0) void'(sb[i].pop_front());
    end
    if (in_valid && exp_rdy) sb[s].push_back(f);
    rdy_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; f = '0; s = '0; in_valid = 1'b0; out_ready = '0;
    rdy_en = 1'b0; exp_rdy = 1'b0;
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single word to lane b
    in_valid = 1'b1; s = 2'd1; f = 32'h1111_0000;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'h2);
    chk("t1_b", b, 32'h1111_0000);
    chk("t1_lane_cnt", 32'(lane_cnt), 32'h04);
    chk("t1_a", a, 32'h0);
    chk("t1_c", c, 32'h0);
    chk("t1_d", d, 32'h0);
    out_ready = 4'b0010;
    step();
    out_ready = 4'b0000;

    // Lane 2 full, then drain
    in_valid = 1'b1; s = 2'd2; f = 32'hA;
    step();
    f = 32'hB;
    step();
    f = 32'hC;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_cnt2", 32'(lane_cnt[5:4]), 32'h2);
    chk("full_c_head", c, 32'hA);
    step();
    out_ready = 4'b0100;
    step();
    chk("drain_c_B", c, 32'hB);
    chk("drain_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("drain_c_C", c, 32'hC);
    in_valid = 1'b0;
    step();
    out_ready = 4'b0000;

    // Head-of-line isolation: lane 0 full, lane 3 still accepts
    in_valid = 1'b1; s = 2'd0; f = 32'h10;
    step();
    f = 32'h11;
    step();
    s = 2'd3; f = 32'h55;
    #1;
    chk("hol_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("hol_d", d, 32'h55);
    chk("hol_a", a, 32'h10);
    chk("hol_cnt0", 32'(lane_cnt[1:0]), 32'h2);

    // Simultaneous push and pop on lane 3 at cnt=1
    out_ready = 4'b1000;
    step();
    out_ready = 4'b0000;
    in_valid = 1'b1; s = 2'd3; f = 32'h1;
    step();
    f = 32'h2; out_ready = 4'b1000;
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("pp_d", d, 32'h2);
    chk("pp_cnt3", 32'(lane_cnt[7:6]), 32'h1);

    // Async reset with lanes 0 and 2 full
    in_valid = 1'b1; s = 2'd2; f = 32'h20;
    step();
    f = 32'h21;
    step();
    in_valid = 1'b0;
    chk("pre_rst_cnt", 32'(lane_cnt), 32'h62);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_lane_cnt", 32'(lane_cnt), 32'h0);
    chk("rst_a", a, 32'h0);
    chk("rst_b", b, 32'h0);
    chk("rst_c", c, 32'h0);
    chk("rst_d", d, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 4; i++) sb[i].delete();
    rdy_en = 1'b0;
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; s = 2'd0; f = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);

    // Random traffic; stalled words are held stable
    for (int n = 0; n < 10000; n++) begin
      if (!(in_valid && !exp_rdy)) begin
        in_valid = 1'($urandom_range(0, 1));
        s        = 2'($urandom_range(0, 3));
        f        = $urandom;
      end
      out_ready = 4'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0;
    out_ready = 4'b1111;
    step();
    step();
    step();
    chk("final_empty", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
